// File: rtl/stream_codec.sv
// stream_codec: keyed-LFSR streaming encoder/decoder with valid/ready on both sides.
// Modes (sampled on the first beat of a frame): 00 bypass, 01 XOR, 10 chain-enc, 11 chain-dec.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   key_in, key_load           LFSR seed and its capture strobe (honoured only while idle)
//   key_err_clr, key_err       sticky error for rejected key loads, and its clear
//   mode                       coding mode for the next frame
//   in_data/in_last/in_valid/in_ready     upstream beat handshake
//   out_data/out_last/out_valid/out_ready downstream beat handshake (registered)
//   busy                       a frame is in progress
//   frames_done                count of completed frames (wraps)
module stream_codec #(
  parameter int unsigned DATA_W = 8,
  parameter logic [31:0] POLY   = 32'h80200003,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       key_in,
  input  logic              key_load,
  input  logic              key_err_clr,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              key_err,
  output logic [CNT_W-1:0]  frames_done
);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_key;
  logic [31:0]       r_lfsr;
  logic [DATA_W-1:0] r_prev;
  logic [1:0]        r_mode;

  logic              w_accept;
  logic              w_idle;
  logic              w_key_ok;
  logic              w_key_bad;
  logic [1:0]        w_mode_eff;
  logic [31:0]       w_lfsr_eff;
  logic [31:0]       w_lfsr_nxt;
  logic [DATA_W-1:0] w_prev_eff;
  logic [DATA_W-1:0] w_prev_nxt;
  logic [DATA_W-1:0] w_ks;
  logic [DATA_W-1:0] w_result;

  // Output register empty or draining this cycle -> room for a new beat.
  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_idle   = (r_state == S_IDLE);

  // A key load is only safe when no frame is using the key, including the beat starting one now.
  assign w_key_ok  = key_load && w_idle && !w_accept;
  assign w_key_bad = key_load && !w_key_ok;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: every accepted beat either ends the frame or leaves it open.
  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) w_state_nxt = in_last ? S_IDLE : S_ACTIVE;
  end

  // First beat of a frame sees the live mode, the seed and a zero chain value.
  always_comb begin
    w_mode_eff = w_idle ? mode   : r_mode;
    w_lfsr_eff = w_idle ? r_key  : r_lfsr;
    w_prev_eff = w_idle ? '0     : r_prev;
    w_ks       = w_lfsr_eff[DATA_W-1:0];
    w_result   = in_data;
    w_prev_nxt = r_prev;
    case (w_mode_eff)
      2'b00: w_result = in_data;
      2'b01: w_result = in_data ^ w_ks;
      2'b10: begin
        w_result   = in_data ^ w_ks ^ w_prev_eff;
        w_prev_nxt = w_result;
      end
      default: begin
        w_result   = in_data ^ w_ks ^ w_prev_eff;
        w_prev_nxt = in_data;
      end
    endcase
    // Galois step, taken on every accepted beat regardless of mode.
    w_lfsr_nxt = w_lfsr_eff[0] ? ((w_lfsr_eff >> 1) ^ POLY) : (w_lfsr_eff >> 1);
  end

  // Keystream, chaining and key registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key   <= 32'h1;
      r_lfsr  <= 32'h1;
      r_prev  <= '0;
      r_mode  <= 2'b00;
      key_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_lfsr <= w_lfsr_nxt;
        r_prev <= w_prev_nxt;
        r_mode <= w_mode_eff;
      end
      // A zero seed would lock the LFSR at zero.
      if (w_key_ok) r_key <= (key_in == 32'h0) ? 32'h1 : key_in;
      if (w_key_bad)        key_err <= 1'b1;
      else if (key_err_clr) key_err <= 1'b0;
    end
  end

  // Output stage, busy flag and frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data    <= '0;
      out_last    <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      frames_done <= '0;
    end else begin
      busy <= (w_state_nxt == S_ACTIVE);
      if (w_accept) begin
        out_data  <= w_result;
        out_last  <= in_last;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (w_accept && in_last) frames_done <= frames_done + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stream_codec.sv
module tb_stream_codec;

  localparam int unsigned DW    = 8;
  localparam int unsigned CW    = 16;
  localparam logic [31:0] POLY  = 32'h80200003;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   key_in;
  logic          key_load;
  logic          key_err_clr;
  logic [1:0]    mode;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          key_err;
  logic [CW-1:0] frames_done;

  stream_codec #(.DATA_W(DW), .POLY(POLY), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load),
    .key_err_clr(key_err_clr), .mode(mode), .in_data(in_data), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .key_err(key_err),
    .frames_done(frames_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-frame keystream from the captured key, beats queued in order.
  typedef struct { logic [DW-1:0] d; logic l; } beat_t;
  beat_t         exp_q[$];
  logic [DW-1:0] got_q[$];
  logic [31:0]   m_key, m_ks_state;
  logic [DW-1:0] m_chain;
  logic [1:0]    m_mode;
  bit            m_in_frame, m_err;
  logic [CW-1:0] m_frames;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
  endfunction

  task automatic model_reset();
    m_key = 32'h1; m_ks_state = 32'h1; m_chain = '0; m_mode = 2'b00;
    m_in_frame = 0; m_err = 0; m_frames = '0;
    exp_q.delete();
  endtask

  initial model_reset();

  always @(negedge clk) begin
    bit acc, drain, was_in_frame;
    logic [DW-1:0] ks, res;
    beat_t b;
    if (!rst_n) begin
      model_reset();
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_frames", 32'(frames_done), 32'h0);
    end else begin
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("out_data", 32'(out_data), 32'(exp_q[0].d));
        chk("out_last", 32'(out_last), 32'(exp_q[0].l));
      end
      chk("busy", 32'(busy), 32'(m_in_frame));
      chk("key_err", 32'(key_err), 32'(m_err));
      chk("frames_done", 32'(frames_done), 32'(m_frames));
      chk("in_ready", 32'(in_ready), 32'(exp_q.size() == 0 || out_ready));

      acc   = in_valid && (exp_q.size() == 0 || out_ready);
      drain = (exp_q.size() != 0) && out_ready;
      was_in_frame = m_in_frame;
      if (drain) begin
        got_q.push_back(exp_q[0].d);
        void'(exp_q.pop_front());
      end
      if (acc) begin
        if (!m_in_frame) begin
          m_mode = mode; m_ks_state = m_key; m_chain = '0;
        end
        ks = m_ks_state[DW-1:0];
        case (m_mode)
          2'b00: res = in_data;
          2'b01: res = in_data ^ ks;
          2'b10: begin res = in_data ^ ks ^ m_chain; m_chain = res; end
          default: begin res = in_data ^ ks ^ m_chain; m_chain = in_data; end
        endcase
        m_ks_state = lfsr_step(m_ks_state);
        b.d = res; b.l = in_last;
        exp_q.push_back(b);
        m_in_frame = !in_last;
        if (in_last) m_frames = m_frames + CW'(1);
      end
      if (key_load && !was_in_frame && !acc) m_key = (key_in == 0) ? 32'h1 : key_in;
      if (key_load && (was_in_frame || acc)) m_err = 1;
      else if (key_err_clr)                  m_err = 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit last, input logic [1:0] md);
    bit acc;
    int n;
    in_valid = 1; in_data = d; in_last = last; mode = md;
    n = 0;
    do begin
      @(negedge clk); acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 32'h0, 32'h1);
    in_valid = 0; in_last = 0;
  endtask

  task automatic load_key(input logic [31:0] k);
    key_in = k; key_load = 1; tick(); key_load = 0;
  endtask

  task automatic expect_got(input string name, input int idx, input logic [DW-1:0] exp);
    logic [DW-1:0] v;
    v = (idx < got_q.size()) ? got_q[idx] : 'x;
    chk(name, 32'(v), 32'(exp));
  endtask

  initial begin
    logic [DW-1:0] held;
    rst_n = 0; key_in = 0; key_load = 0; key_err_clr = 0; mode = 0;
    in_data = 0; in_last = 0; in_valid = 0; out_ready = 1;
    #1;
    chk("reset_out_data", 32'(out_data), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h1);
    chk("reset_key_err", 32'(key_err), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    tick();

    // XOR mode vector
    load_key(32'hA5);
    got_q.delete();
    send(8'h3C, 0, 2'b01); send(8'h00, 1, 2'b01);
    tick(); tick();
    expect_got("xor_b0", 0, 8'h99);
    expect_got("xor_b1", 1, 8'h51);
    chk("xor_frames", 32'(frames_done), 32'h1);
    chk("xor_busy", 32'(busy), 32'h0);

    // Chained encrypt then decrypt round trip
    got_q.delete();
    send(8'h00, 0, 2'b10); send(8'h00, 1, 2'b10);
    send(8'hA5, 0, 2'b11); send(8'hF4, 1, 2'b11);
    tick(); tick();
    expect_got("enc_b0", 0, 8'hA5);
    expect_got("enc_b1", 1, 8'hF4);
    expect_got("dec_b0", 2, 8'h00);
    expect_got("dec_b1", 3, 8'h00);

    // Backpressure: output must hold while stalled
    got_q.delete();
    out_ready = 0;
    send(8'h11, 0, 2'b01);
    in_valid = 1; in_data = 8'h22; in_last = 0;
    held = 8'hB4;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_hold", 32'(out_data), 32'(held));
      tick();
    end
    in_valid = 0;
    out_ready = 1;
    send(8'h22, 0, 2'b01); send(8'h33, 1, 2'b01);
    tick(); tick();
    expect_got("bp_b0", 0, 8'hB4);
    expect_got("bp_b1", 1, 8'h73);
    expect_got("bp_b2", 2, 8'h18);

    // Zero key, rejected load while busy, error clear
    load_key(32'h0);
    got_q.delete();
    send(8'h00, 0, 2'b01);
    load_key(32'h55);
    chk("key_err_set", 32'(key_err), 32'h1);
    send(8'h00, 1, 2'b01);
    send(8'h00, 1, 2'b01);
    tick(); tick();
    expect_got("zk_b0", 0, 8'h01);
    expect_got("zk_b1", 1, 8'h03);
    expect_got("zk_keep", 2, 8'h01);
    key_err_clr = 1; tick(); key_err_clr = 0;
    chk("key_err_clr", 32'(key_err), 32'h0);

    // Mid-frame mode change ignored until next frame
    load_key(32'hA5);
    got_q.delete();
    send(8'h00, 0, 2'b01); send(8'h00, 0, 2'b00); send(8'h00, 1, 2'b00);
    send(8'h77, 1, 2'b00);
    tick(); tick();
    expect_got("mc_b0", 0, 8'hA5);
    expect_got("mc_b1", 1, 8'h51);
    expect_got("mc_b2", 2, 8'h2B);
    expect_got("mc_next", 3, 8'h77);

    // Async reset mid-frame with a pending output beat
    out_ready = 0;
    send(8'h5A, 0, 2'b01);
    chk("pre_rst_valid", 32'(out_valid), 32'h1);
    chk("pre_rst_busy", 32'(busy), 32'h1);
    rst_n = 0;
    #1;
    chk("async_valid", 32'(out_valid), 32'h0);
    chk("async_busy", 32'(busy), 32'h0);
    tick(); tick();
    rst_n = 1; out_ready = 1;
    tick();
    got_q.delete();
    send(8'h00, 1, 2'b01);
    tick(); tick();
    expect_got("post_rst", 0, 8'h01);

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      in_valid    = ($urandom_range(0, 9) < 7);
      in_data     = DW'($urandom);
      in_last     = ($urandom_range(0, 3) == 0);
      mode        = 2'($urandom);
      key_load    = ($urandom_range(0, 19) == 0);
      key_in      = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      key_err_clr = ($urandom_range(0, 15) == 0);
      out_ready   = ($urandom_range(0, 9) < 7);
      tick();
    end
    in_valid = 0; key_load = 0; key_err_clr = 0; out_ready = 1;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
